// File: rtl/banco_registros.sv
// -----------------------------------------------------------------------------
// banco_registros
//
// Register file for the monocycle datapath, feeding the ALU a/b operands.
// Two combinational read ports, one synchronous write port. Storage is a plain
// RAM-style array without per-entry reset. After reset a clear sequencer sweeps
// every entry to zero, one per cycle. While it runs, ready_o stays low, writes
// are dropped and reads return 0. Register 0 always reads as zero.
//
// Parameters:
//   N       data width (matches the ALU width)
//   ADDR_W  address width; depth is 2**ADDR_W entries
//
// Ports:
//   clk_i    in   1       clock, rising edge
//   rst_i    in   1       synchronous reset, active-high
//   we_i     in   1       write enable (ignored while ready_o=0)
//   wa_i     in   ADDR_W  write address
//   wd_i     in   N       write data
//   ra_a_i   in   ADDR_W  read address, port A (rs)
//   ra_b_i   in   ADDR_W  read address, port B (rt)
//   rd_a_o   out  N       read data A (to ALU a_i)
//   rd_b_o   out  N       read data B (to ALU b_i)
//   ready_o  out  1       clear sweep finished, file usable
//
// Optional feature macro:
//   BANCO_BYPASS_EN  when defined, a read of the address being written in the
//                    same cycle returns wd_i (write-through forwarding), per
//                    port. When undefined, such a read returns the old value.
//
// Write/read contract: there is no handshake. A write is accepted on any rising
// edge where ready_o=1, we_i=1 and wa_i!=0; otherwise it is lost. Reads are
// valid whenever ready_o=1. The control unit must stall while ready_o=0.
// -----------------------------------------------------------------------------
module banco_registros #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [N-1:0]      wd_i,
  input  logic [ADDR_W-1:0] ra_a_i,
  input  logic [ADDR_W-1:0] ra_b_i,
  output logic [N-1:0]      rd_a_o,
  output logic [N-1:0]      rd_b_o,
  output logic              ready_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_Z   = '0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]        mem_q [DEPTH];

  // Array write port, shared between the clear sweep and normal write-back.
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [N-1:0]        mem_wd;

  logic                run_wr;

  assign ready_o = (state_q == ST_RUN);
  assign run_wr  = ready_o && we_i && (wa_i != ADDR_Z);

  // ---------------------------------------------------------------------------
  // FSM: state and sweep counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and array write selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = wa_i;
    mem_wd  = wd_i;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        // Counter wraps to 0 on the last entry; it is not used in RUN.
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = run_wr;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    // The reset edge must not touch the array.
    if (rst_i) begin
      mem_we = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset on the array itself, the sweep clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_a_o = '0;
    if (ready_o && (ra_a_i != ADDR_Z)) begin
      rd_a_o = mem_q[ra_a_i];
`ifdef BANCO_BYPASS_EN
      if (we_i && (wa_i == ra_a_i)) begin
        rd_a_o = wd_i;
      end
`endif
    end
  end

  always_comb begin
    rd_b_o = '0;
    if (ready_o && (ra_b_i != ADDR_Z)) begin
      rd_b_o = mem_q[ra_b_i];
`ifdef BANCO_BYPASS_EN
      if (we_i && (wa_i == ra_b_i)) begin
        rd_b_o = wd_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_banco_registros.sv
// -----------------------------------------------------------------------------
// tb_banco_registros
//
// Directed testbench for banco_registros (N=32, ADDR_W=5). Inputs are driven
// on the falling edge and outputs sampled shortly afterwards, away from the
// rising edge where the DUT updates.
// -----------------------------------------------------------------------------
module tb_banco_registros;

  localparam int N      = 32;
  localparam int ADDR_W = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              we_i;
  logic [ADDR_W-1:0] wa_i;
  logic [N-1:0]      wd_i;
  logic [ADDR_W-1:0] ra_a_i;
  logic [ADDR_W-1:0] ra_b_i;
  logic [N-1:0]      rd_a_o;
  logic [N-1:0]      rd_b_o;
  logic              ready_o;

  always #5 clk_i = ~clk_i;

  banco_registros #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we_i),
    .wa_i    (wa_i),
    .wd_i    (wd_i),
    .ra_a_i  (ra_a_i),
    .ra_b_i  (ra_b_i),
    .rd_a_o  (rd_a_o),
    .rd_b_o  (rd_b_o),
    .ready_o (ready_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One full cycle: rising edge (DUT updates) then falling edge (drive point).
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
    we_i = 1'b1;
    wa_i = a;
    wd_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    ra_a_i = a;
    ra_b_i = b;
    #1;
  endtask

  // Watchdog: the directed flow is fixed-length, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_i  = 1'b1;
    we_i   = 1'b0;
    wa_i   = '0;
    wd_i   = '0;
    ra_a_i = 5'd31;
    ra_b_i = 5'd2;

    // Reset held for 3 edges.
    repeat (3) tick();
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_rd_a", rd_a_o, 32'd0);
    chk("rst_rd_b", rd_b_o, 32'd0);

    // Release and watch the sweep; a write lands on sweep edge 10 and is lost.
    rst_i = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      if (e == 10) begin
        we_i = 1'b1;
        wa_i = 5'd4;
        wd_i = 32'hFF;
      end
      tick();
      if (e == 10) we_i = 1'b0;
      #1;
      if (e <= 31) chk($sformatf("sweep_ready_e%0d", e), {31'd0, ready_o}, 32'd0);
      else         chk("sweep_ready_e32", {31'd0, ready_o}, 32'd1);
      if (e == 5) chk("sweep_rd_gated", rd_a_o, 32'd0);
    end

    // Every entry reads zero after the sweep.
    for (int i = 1; i < 32; i++) begin
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
    end
    for (int i = 1; i < 32; i++) begin
      rd(ADDR_W'(i), ADDR_W'(32 - i));
      chk($sformatf("clr_a_r%0d", i), rd_a_o, exp_q.pop_front());
      chk($sformatf("clr_b_r%0d", 32 - i), rd_b_o, exp_q.pop_front());
    end
    rd(5'd4, 5'd4);
    chk("wr_during_clear_r4", rd_a_o, 32'd0);

    // Basic write/read, register 0.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    chk("r5_read", rd_a_o, 32'hDEADBEEF);
    wr(5'd0, 32'h1234);
    rd(5'd5, 5'd0);
    chk("r0_read", rd_b_o, 32'd0);

    // Dual port.
    wr(5'd7, 32'hA5A5A5A5);
    wr(5'd9, 32'h0F0F0F0F);
    rd(5'd7, 5'd9);
    chk("dual_a_r7", rd_a_o, 32'hA5A5A5A5);
    chk("dual_b_r9", rd_b_o, 32'h0F0F0F0F);
    rd(5'd7, 5'd7);
    chk("same_a_r7", rd_a_o, 32'hA5A5A5A5);
    chk("same_b_r7", rd_b_o, 32'hA5A5A5A5);

    // Same-cycle write/read hazard on r3.
    wr(5'd3, 32'h11);
    we_i = 1'b1;
    wa_i = 5'd3;
    wd_i = 32'h22;
    rd(5'd3, 5'd9);
`ifdef BANCO_BYPASS_EN
    chk("hazard_same_cycle", rd_a_o, 32'h22);
`else
    chk("hazard_same_cycle", rd_a_o, 32'h11);
`endif
    chk("hazard_other_port", rd_b_o, 32'h0F0F0F0F);
    tick();
    we_i = 1'b0;
    #1;
    chk("hazard_next_cycle", rd_a_o, 32'h22);

    // Reset mid-operation.
    wr(5'd12, 32'h55);
    rd(5'd12, 5'd12);
    chk("r12_before_rst", rd_a_o, 32'h55);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready_o}, 32'd0);
    chk("midrst_rd_gated", rd_a_o, 32'd0);
    for (int e = 1; e <= 32; e++) begin
      tick();
      #1;
      if (e == 1 || e == 31) chk($sformatf("resweep_ready_e%0d", e), {31'd0, ready_o}, 32'd0);
      if (e == 32)           chk("resweep_ready_e32", {31'd0, ready_o}, 32'd1);
    end
    rd(5'd12, 5'd5);
    chk("r12_after_rst", rd_a_o, 32'd0);
    chk("r5_after_rst", rd_b_o, 32'd0);

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
